// File: rtl/eco_sweep_pkg.sv
// Shared types and constants for the ECO exhaustive-sweep controller and its signature register.
package eco_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int              SIG_W    = 16;
  localparam logic [SIG_W-1:0] SIG_POLY = 16'h1021;
  localparam logic [SIG_W-1:0] SIG_SEED = 16'hFFFF;

  // One MISR shift: left shift, feedback polynomial on the MSB, data folded into bit 0.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s, input logic d);
    return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? SIG_POLY : {SIG_W{1'b0}}) ^ {{(SIG_W-1){1'b0}}, d};
  endfunction

endpackage

// File: rtl/eco_sweep_misr.sv
// Multiple-input signature register over the revised netlist output; seeded at sweep start,
// advanced on each accepted sample, held otherwise.
module eco_sweep_misr
  import eco_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             seed,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (seed) begin
      sig_d = SIG_SEED;
    end else if (en) begin
      sig_d = misr_step(sig_q, din);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/eco_sweep_ctrl.sv
// Exhaustive input-pattern sequencer comparing a golden and a revised netlist.
// Optional signature of revised_b is built when SIG_MISR_EN is defined; otherwise sig reads 0.
module eco_sweep_ctrl
  import eco_sweep_pkg::*;
#(
  parameter int IN_W   = 6,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [IN_W-1:0]  pat,
  input  logic             golden_b,
  input  logic             revised_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IN_W:0]    mism_cnt,
  output logic             first_valid,
  output logic [IN_W-1:0]  first_mism,
  output logic [SIG_W-1:0] sig
);

  localparam logic [3:0]      SETTLE_C = 4'(SETTLE);
  localparam logic [IN_W-1:0] PAT_LAST = '1;
  localparam logic [IN_W-1:0] PAT_ONE  = {{(IN_W-1){1'b0}}, 1'b1};
  localparam logic [IN_W:0]   CNT_ONE  = {{IN_W{1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [IN_W-1:0] pat_q, pat_d;
  logic [3:0]      settle_q, settle_d;
  logic [IN_W:0]   mism_q, mism_d;
  logic            fv_q, fv_d;
  logic [IN_W-1:0] fm_q, fm_d;
  logic            at_sample;

  assign at_sample = (state_q == ST_RUN) && (settle_q == SETTLE_C);

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    settle_d = settle_q;
    mism_d   = mism_q;
    fv_d     = fv_q;
    fm_d     = fm_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_RUN;
          pat_d    = '0;
          settle_d = '0;
          mism_d   = '0;
          fv_d     = 1'b0;
          fm_d     = '0;
        end
      end
      ST_RUN: begin
        // Abort outranks both a pending start and a coincident sample.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!at_sample) begin
          settle_d = settle_q + 4'd1;
        end else begin
          if (golden_b != revised_b) begin
            mism_d = mism_q + CNT_ONE;
            if (!fv_q) begin
              fv_d = 1'b1;
              fm_d = pat_q;
            end
          end
          if (pat_q == PAT_LAST) begin
            state_d = ST_DONE;
          end else begin
            pat_d    = pat_q + PAT_ONE;
            settle_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pat_q    <= '0;
      settle_q <= '0;
      mism_q   <= '0;
      fv_q     <= 1'b0;
      fm_q     <= '0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      settle_q <= settle_d;
      mism_q   <= mism_d;
      fv_q     <= fv_d;
      fm_q     <= fm_d;
    end
  end

  assign pat         = pat_q;
  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign pass        = done && (mism_q == '0);
  assign mism_cnt    = mism_q;
  assign first_valid = fv_q;
  assign first_mism  = fm_q;

`ifdef SIG_MISR_EN
  logic sig_seed, sig_en;
  assign sig_seed = start && (state_q != ST_RUN);
  assign sig_en   = at_sample && !abort;

  eco_sweep_misr u_misr (
    .clk  (clk),
    .rst  (rst),
    .seed (sig_seed),
    .en   (sig_en),
    .din  (revised_b),
    .sig  (sig)
  );
`else
  assign sig = '0;
`endif

endmodule
